multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle 32-bit MIPS-subset core.
- Sequences fetch/decode/execute/memory/writeback over the shared ALU, register file and single memory port.
- Drives all datapath muxes and write enables, including ext_sel for the immediate-extension stage: zero-extend for andi/ori, sign-extend otherwise.
- Adds a memory ready handshake with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles a memory-wait state holds mem_req without mem_ready before abort.
- CNT_W, 4: width of the timeout counter. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from IR; sampled in DECODE
- funct  in  6  instr[5:0] from IR; sampled in DECODE
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepted write / read data valid this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write
- iord  out  1  address source: 0 = PC, 1 = ALUOut
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load
- reg_we  out  1  register file write
- reg_dst  out  1  destination: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  ALU A: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
- alu_ctrl  out  3  ALU op: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT
- pc_src  out  2  PC next: 00 = ALU result, 01 = ALUOut, 10 = jump target
- ext_sel  out  1  1 = sign-extend, 0 = zero-extend
- illegal_op  out  1  one-cycle pulse on undecodable instruction
- bus_err  out  1  one-cycle pulse on memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (async, reset_n=0):
  - state = IDLE; op_q = 0, funct_q = 0, counter = 0.
  - All outputs 0, except ext_sel = 1 and alu_ctrl = 010.
  - IDLE -> FETCH unconditionally on the first clock after reset release.
- Opcodes: R=0x00, lw=0x23, sw=0x2B, beq=0x04, addi=0x08, andi=0x0C, ori=0x0D, j=0x02.
- Functs: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
- All unlisted outputs are 0 in a state.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ADD.
  - When mem_ready=1 (same cycle): ir_we=1, pc_we=1, pc_src=00, then -> DECODE.
- DECODE:
  - Latches opcode/funct into op_q/funct_q.
  - Drives alu_src_a=0, alu_src_b=11, ADD, ext_sel=1 (branch target).
  - Next state: lw/sw -> MEMADR; R -> EXEC_R; beq -> BRANCH; addi/andi/ori -> EXEC_I; j -> JUMP.
  - Any other opcode: illegal_op=1, -> FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD, ext_sel=1; -> MEMRD if lw, else MEMWR.
- MEMRD: mem_req=1, iord=1; on mem_ready -> MEMWB.
- MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1; -> FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1; on mem_ready -> FETCH.
- EXEC_R:
  - alu_src_a=1, alu_src_b=00, alu_ctrl decoded from funct_q; -> ALUWB.
  - Unknown funct: illegal_op=1 and -> FETCH, so no writeback occurs.
- ALUWB: reg_we=1, reg_dst=1; -> FETCH.
- EXEC_I:
  - alu_src_a=1, alu_src_b=10.
  - ALU op: addi ADD, andi AND, ori OR.
  - ext_sel=0 for andi/ori, 1 for addi.
  - -> IMMWB, which holds the same ext_sel.
- IMMWB: reg_we=1, reg_dst=0, mem_to_reg=0; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_we=zero; -> FETCH.
- JUMP: pc_src=10, pc_we=1; -> FETCH.
- Timeout watchdog:
  - Counter clears on entry to FETCH/MEMRD/MEMWR and increments each wait cycle.
  - If counter reaches MEM_TIMEOUT with mem_ready=0: bus_err=1 for that cycle, no write enables, next state FETCH.
  - A FETCH timeout re-enters FETCH with the counter cleared.
  - mem_ready=1 on the timeout cycle takes priority: normal completion, no bus_err.
- mem_ready outside a wait state is ignored.
- reset_n low mid-instruction aborts immediately to IDLE; no partial writes follow.
- CPI: lw 5, sw 4, R/I-type 4, beq/j 3, each plus memory wait cycles.

Decomposition:
- Shared package control_defs:
  - opcode and funct constants
  - alu_ctrl codes
  - alu_src_b and pc_src encodings
  - state encodings: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB, EXEC_I, IMMWB, BRANCH, JUMP
- One sub-module, alu_decoder: combinational (op_q, funct_q, state) -> alu_ctrl, funct_illegal.

Test Plan:
1. Reset, then release with mem_ready tied 1 -> IDLE one cycle, FETCH asserts mem_req; ir_we and pc_we pulse together.
2. andi (op 0x0C) with mem_ready=1 -> states FETCH, DECODE, EXEC_I, IMMWB; ext_sel=0 and alu_ctrl=000 in EXEC_I/IMMWB; reg_we=1, reg_dst=0 in IMMWB; 4 cycles total.
3. lw with mem_ready delayed 3 cycles in MEMRD -> mem_req held 4 cycles, then MEMWB with mem_to_reg=1; instruction takes 8 cycles.
4. beq with zero=1, then zero=0 -> pc_we=1 with pc_src=01 in BRANCH, then pc_we=0; both return to FETCH.
5. Opcode 0x3F, then R-type funct 0x3F -> illegal_op pulses once in DECODE, then once in EXEC_R; no reg_we in either case.
6. sw with mem_ready never asserted, MEM_TIMEOUT=15 -> bus_err pulses once after 15 wait cycles, mem_we drops, FETCH re-entered; reset_n low mid-wait forces IDLE with all outputs at reset values.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: opcodes, functs,
// ALU codes, mux selects and FSM state encodings.
package control_defs;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pcsrc_e;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_ALUWB, S_EXEC_I, S_IMMWB, S_BRANCH, S_JUMP
    } state_e;

    // Logical immediates take a zero-extended operand; everything else sign-extends.
    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: IR fields and flags in, mux selects and enables out.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       ext_sel;
    logic       illegal_op;
    logic       bus_err;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_ctrl, pc_src, ext_sel, illegal_op,
               bus_err, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_ctrl, pc_src, ext_sel, illegal_op,
               bus_err, state_dbg
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation select from the current state and the latched opcode/funct;
// flags an R-type funct that the datapath cannot execute.
module alu_decoder
    import control_defs::*;
(
    input  state_e     state,
    input  logic [5:0] op_q,
    input  logic [5:0] funct_q,
    output alu_op_e    alu_ctrl,
    output logic       funct_illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        alu_ctrl      = ALU_AND;
        funct_illegal = 1'b0;
        unique case (state)
            S_IDLE, S_FETCH, S_DECODE, S_MEMADR: alu_ctrl = ALU_ADD;
            S_BRANCH:                            alu_ctrl = ALU_SUB;
            S_EXEC_R: begin
                unique case (funct_q)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            // The writeback cycle keeps the execute op so ALUOut-side logic sees a stable code.
            S_EXEC_I, S_IMMWB: begin
                unique case (op_q)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset core with a memory ready
// handshake and a timeout watchdog on every memory-wait state.
module multicycle_control
    import control_defs::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input logic                  clk,
    input logic                  reset_n,
    multicycle_control_if.master bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       op_q, funct_q;
    logic             waiting, timeout, zext, funct_illegal;
    alu_op_e          dec_alu;

    alu_decoder u_alu_decoder (
        .state         (state_q),
        .op_q          (op_q),
        .funct_q       (funct_q),
        .alu_ctrl      (dec_alu),
        .funct_illegal (funct_illegal)
    );

    assign waiting = (state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !bus.mem_ready;
    assign timeout = waiting && (cnt_q == TIMEOUT_CNT);
    assign zext    = is_zero_ext(op_q);

    // Selects follow the registered state; enables that complete a handshake
    // (ir_we, pc_we, bus_err, illegal_op) also look at same-cycle inputs.
    always_comb begin
        state_d        = state_q;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_REG;
        bus.alu_ctrl   = dec_alu;
        bus.pc_src     = PC_ALU;
        bus.ext_sel    = 1'b1;
        bus.illegal_op = 1'b0;
        bus.bus_err    = 1'b0;
        bus.state_dbg  = state_q;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_req   = !timeout;
                bus.alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout) begin
                    bus.bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SH2;
                unique case (bus.opcode)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_R:                     state_d = S_EXEC_R;
                    OP_BEQ:                   state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
                    OP_J:                     state_d = S_JUMP;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD, S_MEMWR: begin
                bus.mem_req = !timeout;
                bus.mem_we  = (state_q == S_MEMWR) && !timeout;
                bus.iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (timeout) begin
                    bus.bus_err = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_MEMWB: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXEC_R: begin
                bus.alu_src_a  = 1'b1;
                bus.illegal_op = funct_illegal;
                state_d        = funct_illegal ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_we  = 1'b1;
                bus.reg_dst = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.ext_sel   = !zext;
                state_d       = S_IMMWB;
            end
            S_IMMWB: begin
                bus.reg_we  = 1'b1;
                bus.ext_sel = !zext;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.pc_src    = PC_ALUOUT;
                bus.pc_we     = bus.zero;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_src = PC_JUMP;
                bus.pc_we  = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q    <= bus.opcode;
                funct_q <= bus.funct;
            end
            // A timeout in FETCH loops back into FETCH, so it must clear like a fresh entry.
            if (state_d != state_q || timeout) begin
                cnt_q <= '0;
            end else if (waiting) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
